id_ex_stage: RTL

ID/EX pipeline stage register for the five-stage MIPS core, sitting directly downstream of the instruction-decode controller.
- Each cycle it latches the controller's control lines, register-file read data, extended immediate and register specifiers into EX-stage outputs.
- It contains the load-use hazard detector: it stalls IF/ID and the PC and inserts exactly one bubble.
- It honours a branch/jump flush from ID and a whole-pipe hold from downstream.
- It keeps a saturating count of load-use stalls for performance debug.

---
 rtl/id_ex_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush, hold and a stall counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W = 5,
    parameter logic [3:0] ALU_NOP = 4'hF,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_aluop,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_writemem,
    input  logic              id_readmem,
    input  logic              id_memtoreg,
    input  logic [1:0]        id_shift,
    input  logic              id_branch,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid,
    output logic [3:0]        ex_aluop,
    output logic              ex_alusrc,
    output logic              ex_writemem,
    output logic              ex_readmem,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic [1:0]        ex_shift,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_shamt,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_wreg,
    output logic              stall_o,
    output logic [15:0]       lu_stall_cnt
);
    logic uses_rs, uses_rt, load_use, bubble;

    // Loads are recognised by memtoreg&regwrite since branches also drive readmem
    always_comb begin
        uses_rs = id_shift == 2'b00;
        uses_rt = ~id_alusrc | id_writemem | id_branch;
        load_use = id_valid & ex_valid & ex_memtoreg & ex_regwrite & (ex_wreg != '0) &
                   ((uses_rs & (ex_wreg == id_rs)) | (uses_rt & (ex_wreg == id_rt)));
        stall_o = hold_i | load_use;
        bubble = flush_i | load_use | ~id_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_aluop     <= ALU_NOP;
            ex_alusrc    <= 1'b0;
            ex_writemem  <= 1'b0;
            ex_readmem   <= 1'b0;
            ex_memtoreg  <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_shift     <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_imm       <= '0;
            ex_shamt     <= '0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_wreg      <= '0;
            lu_stall_cnt <= '0;
        end else if (!hold_i) begin
            if (load_use && lu_stall_cnt != CNT_MAX)
                lu_stall_cnt <= lu_stall_cnt + 16'd1;
            ex_valid     <= ~bubble;
            ex_aluop     <= bubble ? ALU_NOP : id_aluop;
            ex_alusrc    <= ~bubble & id_alusrc;
            ex_writemem  <= ~bubble & id_writemem;
            ex_readmem   <= ~bubble & id_readmem;
            ex_memtoreg  <= ~bubble & id_memtoreg;
            ex_regwrite  <= ~bubble & id_regwrite;
            ex_shift     <= bubble ? '0 : id_shift;
            ex_rs_data   <= bubble ? '0 : id_rs_data;
            ex_rt_data   <= bubble ? '0 : id_rt_data;
            ex_imm       <= bubble ? '0 : id_imm;
            ex_shamt     <= bubble ? '0 : id_shamt;
            ex_rs        <= bubble ? '0 : id_rs;
            ex_rt        <= bubble ? '0 : id_rt;
            ex_wreg      <= bubble ? '0 : (id_regdst ? id_rd : id_rt);
        end
    end
endmodule
